wbm_template: RTL

Parameterized single-transfer Wishbone classic master that turns a simple valid/ready command port from fabric logic into one Wishbone read or write cycle. It returns the captured read data, or an error/timeout status, on a one-cycle response strobe. It is the bus-initiator counterpart to the team's Wishbone slave blocks. It drives register-map slaves on the same `wb_clk_i` domain with byte-enable, address and data widths matching theirs.

---
 rtl/wbm_template_if.sv | 44 ++++
 rtl/wbm_template.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/wbm_template_if.sv
// Command/response port and Wishbone master signals of wbm_template.
// The master modport is the block's view; the slave modport is the environment's view.
interface wbm_template_if #(
  parameter int BUS_DATA_WIDTH = 32,
  parameter int BUS_ADDR_WIDTH = 8
);
  localparam int BYTE_EN_WIDTH = BUS_DATA_WIDTH / 8;

  logic                      cmd_valid_i;
  logic                      cmd_ready_o;
  logic                      cmd_we_i;
  logic [BUS_ADDR_WIDTH-1:0] cmd_adr_i;
  logic [BUS_DATA_WIDTH-1:0] cmd_dat_i;
  logic [BYTE_EN_WIDTH-1:0]  cmd_sel_i;

  logic                      rsp_valid_o;
  logic [BUS_DATA_WIDTH-1:0] rsp_dat_o;
  logic                      rsp_err_o;
  logic                      rsp_timeout_o;

  logic                      wbm_cyc_o;
  logic                      wbm_stb_o;
  logic                      wbm_we_o;
  logic [BYTE_EN_WIDTH-1:0]  wbm_sel_o;
  logic [BUS_ADDR_WIDTH-1:0] wbm_adr_o;
  logic [BUS_DATA_WIDTH-1:0] wbm_dat_o;
  logic [BUS_DATA_WIDTH-1:0] wbm_dat_i;
  logic                      wbm_ack_i;
  logic                      wbm_err_i;

  modport master (
    input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
    input  wbm_dat_i, wbm_ack_i, wbm_err_i,
    output cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o, rsp_timeout_o,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );

  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
    output wbm_dat_i, wbm_ack_i, wbm_err_i,
    input  cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o, rsp_timeout_o,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );
endinterface

// File: rtl/wbm_template.sv
// Single-transfer Wishbone classic master: one valid/ready command becomes one
// bus cycle, answered by a one-cycle response strobe carrying data or error/timeout.
module wbm_template #(
  parameter int BUS_DATA_WIDTH = 32,
  parameter int BUS_ADDR_WIDTH = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_i,
  wbm_template_if.master bus
);
  localparam int BYTE_EN_WIDTH = BUS_DATA_WIDTH / 8;
  localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUS, RESP, DRAIN} state_t;

  state_t                    state, state_nxt;
  logic [CNT_WIDTH-1:0]      cnt, cnt_nxt;
  logic                      cmd_ready, cmd_ready_nxt;
  logic                      cyc, cyc_nxt;
  logic                      we, we_nxt;
  logic [BYTE_EN_WIDTH-1:0]  sel, sel_nxt;
  logic [BUS_ADDR_WIDTH-1:0] adr, adr_nxt;
  logic [BUS_DATA_WIDTH-1:0] dat, dat_nxt;
  logic                      rsp_valid, rsp_valid_nxt;
  logic [BUS_DATA_WIDTH-1:0] rsp_dat, rsp_dat_nxt;
  logic                      rsp_err, rsp_err_nxt;
  logic                      rsp_timeout, rsp_timeout_nxt;
  logic                      slave_busy;

  assign slave_busy = bus.wbm_ack_i | bus.wbm_err_i;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state       <= IDLE;
      cnt         <= '0;
      cmd_ready   <= 1'b1;
      cyc         <= 1'b0;
      we          <= 1'b0;
      sel         <= '0;
      adr         <= '0;
      dat         <= '0;
      rsp_valid   <= 1'b0;
      rsp_dat     <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      cmd_ready   <= cmd_ready_nxt;
      cyc         <= cyc_nxt;
      we          <= we_nxt;
      sel         <= sel_nxt;
      adr         <= adr_nxt;
      dat         <= dat_nxt;
      rsp_valid   <= rsp_valid_nxt;
      rsp_dat     <= rsp_dat_nxt;
      rsp_err     <= rsp_err_nxt;
      rsp_timeout <= rsp_timeout_nxt;
    end
  end

  // The same counter bounds both the wait for ack/err and the wait for its release.
  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    cyc_nxt         = cyc;
    we_nxt          = we;
    sel_nxt         = sel;
    adr_nxt         = adr;
    dat_nxt         = dat;
    rsp_valid_nxt   = 1'b0;
    rsp_dat_nxt     = rsp_dat;
    rsp_err_nxt     = rsp_err;
    rsp_timeout_nxt = rsp_timeout;
    case (state)
      IDLE: begin
        if (bus.cmd_valid_i && cmd_ready) begin
          we_nxt    = bus.cmd_we_i;
          sel_nxt   = bus.cmd_sel_i;
          adr_nxt   = bus.cmd_adr_i;
          dat_nxt   = bus.cmd_dat_i;
          cyc_nxt   = 1'b1;
          cnt_nxt   = '0;
          state_nxt = BUS;
        end
      end
      BUS: begin
        if (bus.wbm_err_i) begin
          state_nxt       = RESP;
          cyc_nxt         = 1'b0;
          rsp_valid_nxt   = 1'b1;
          rsp_err_nxt     = 1'b1;
          rsp_timeout_nxt = 1'b0;
          rsp_dat_nxt     = '0;
        end else if (bus.wbm_ack_i) begin
          state_nxt       = RESP;
          cyc_nxt         = 1'b0;
          rsp_valid_nxt   = 1'b1;
          rsp_err_nxt     = 1'b0;
          rsp_timeout_nxt = 1'b0;
          rsp_dat_nxt     = we ? '0 : bus.wbm_dat_i;
        end else if (cnt == CNT_LAST) begin
          state_nxt       = RESP;
          cyc_nxt         = 1'b0;
          rsp_valid_nxt   = 1'b1;
          rsp_err_nxt     = 1'b1;
          rsp_timeout_nxt = 1'b1;
          rsp_dat_nxt     = '0;
        end else begin
          cnt_nxt = cnt + CNT_WIDTH'(1);
        end
      end
      RESP: begin
        cnt_nxt   = '0;
        state_nxt = slave_busy ? DRAIN : IDLE;
      end
      DRAIN: begin
        if (!slave_busy || cnt == CNT_LAST) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + CNT_WIDTH'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
    cmd_ready_nxt = (state_nxt == IDLE);
  end

  assign bus.cmd_ready_o   = cmd_ready;
  assign bus.rsp_valid_o   = rsp_valid;
  assign bus.rsp_dat_o     = rsp_dat;
  assign bus.rsp_err_o     = rsp_err;
  assign bus.rsp_timeout_o = rsp_timeout;
  assign bus.wbm_cyc_o     = cyc;
  assign bus.wbm_stb_o     = cyc;
  assign bus.wbm_we_o      = we;
  assign bus.wbm_sel_o     = sel;
  assign bus.wbm_adr_o     = adr;
  assign bus.wbm_dat_o     = dat;
endmodule
